cam_capture_win: RTL and testbench

//  Parametrised successor to the fixed OV7670 capture stage. Packs the camera byte stream into
//  BPP-byte pixels, crops to a runtime window, decimates by 2^n in X/Y, and writes to the output

---
 rtl/cam_capture_win_pkg.sv | 22 ++
 rtl/cam_capture_win_pix_pack.sv | 50 +++++
 rtl/cam_capture_win.sv | 171 +++++++++++++++++
 tb/tb_cam_capture_win.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_win_pkg.sv
// Shared definitions for the camera capture window block:
// FSM state encoding, default OV7670 geometry and the decimation phase helper.
package cam_capture_win_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2
  } cap_state_e;

  localparam int unsigned CAM_DEF_WIDTH  = 640;
  localparam int unsigned CAM_DEF_HEIGHT = 480;
  localparam int unsigned CAM_DEF_BPP    = 2;

  // True when the offset from the window origin is a multiple of 2^decim.
  function automatic logic decim_hit(input logic [31:0] ofs, input logic [1:0] decim);
    logic [31:0] mask;
    mask = (32'd1 << decim) - 32'd1;
    return (ofs & mask) == '0;
  endfunction

endpackage

// File: rtl/cam_capture_win_pix_pack.sv
// Byte-to-pixel packer: shifts BPP camera bytes MSB-first into one pixel and
// flags completion for one cycle. Any partial pixel is discarded while en is low.
module cam_capture_win_pix_pack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BPP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     data,
  output logic                  pixel_valid,
  output logic [DATA_W*BPP-1:0] pixel
);

  localparam int unsigned PW  = DATA_W * BPP;
  localparam int unsigned BCW = (BPP > 1) ? $clog2(BPP) : 1;

  logic [BCW-1:0] byte_cnt;
  logic [PW-1:0]  shreg;
  logic [PW-1:0]  sh_next;

  // Shift form keeps BPP=1 legal (no zero-width slice).
  always_comb begin
    sh_next = (shreg << DATA_W) | PW'(data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      shreg       <= '0;
      pixel_valid <= 1'b0;
      pixel       <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (en) begin
        shreg <= sh_next;
        if (byte_cnt == BCW'(BPP - 1)) begin
          byte_cnt    <= '0;
          pixel_valid <= 1'b1;
          pixel       <= sh_next;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cam_capture_win.sv
// Camera capture stage: packs bytes into pixels, crops to a runtime window,
// decimates by 2^n and writes to the output FIFO, dropping a frame on back-pressure.
module cam_capture_win
  import cam_capture_win_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BPP    = CAM_DEF_BPP,
  parameter int unsigned X_W    = $clog2(CAM_DEF_WIDTH),
  parameter int unsigned Y_W    = $clog2(CAM_DEF_HEIGHT),
  parameter int unsigned FCNT_W = 16
) (
  input  logic                  i_pclk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_done,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [X_W-1:0]        i_x_start,
  input  logic [X_W-1:0]        i_x_end,
  input  logic [Y_W-1:0]        i_y_start,
  input  logic [Y_W-1:0]        i_y_end,
  input  logic [1:0]            i_decim,
  input  logic                  i_fifo_almostfull,
  input  logic                  i_clr_ovf,
  output logic                  o_wr,
  output logic [DATA_W*BPP-1:0] o_wdata,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic [FCNT_W-1:0]     o_frame_cnt,
  output logic                  o_ovf
);

  cap_state_e state;

  logic              vs_r, vs_d, href_r, href_d;
  logic [DATA_W-1:0] data_r;
  logic              vs_fall, vs_rise, href_fall;

  logic                  pack_en;
  logic                  pix_valid;
  logic [DATA_W*BPP-1:0] pix;

  logic [X_W-1:0] x, xs, xe, x_ofs;
  logic [Y_W-1:0] y, ys, ye, y_ofs;
  logic [1:0]     decim_l;
  logic           drop;
  logic           in_win, wr_elig, ovf_set;

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_r   <= 1'b0;
      vs_d   <= 1'b0;
      href_r <= 1'b0;
      href_d <= 1'b0;
      data_r <= '0;
    end else begin
      vs_r   <= i_vsync;
      vs_d   <= vs_r;
      href_r <= i_href;
      href_d <= href_r;
      data_r <= i_data;
    end
  end

  always_comb begin
    vs_fall   = vs_d & ~vs_r;
    vs_rise   = vs_r & ~vs_d;
    href_fall = href_d & ~href_r;
    pack_en   = (state == ST_ACTIVE) && href_r;
    x_ofs     = x - xs;
    y_ofs     = y - ys;
    in_win    = (x >= xs) && (x <= xe) && (y >= ys) && (y <= ye) &&
                decim_hit(32'(x_ofs), decim_l) && decim_hit(32'(y_ofs), decim_l);
    wr_elig   = (state == ST_ACTIVE) && i_cfg_done && !vs_rise &&
                pix_valid && in_win && !drop;
    ovf_set   = wr_elig && i_fifo_almostfull;
  end

  cam_capture_win_pix_pack #(
    .DATA_W (DATA_W),
    .BPP    (BPP)
  ) u_pix_pack (
    .clk         (i_pclk),
    .rst_n       (i_rstn),
    .en          (pack_en),
    .data        (data_r),
    .pixel_valid (pix_valid),
    .pixel       (pix)
  );

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_wr        <= 1'b0;
      o_wdata     <= '0;
      o_frame_cnt <= '0;
      o_ovf       <= 1'b0;
      x           <= '0;
      y           <= '0;
      xs          <= '0;
      xe          <= '0;
      ys          <= '0;
      ye          <= '0;
      decim_l     <= '0;
      drop        <= 1'b0;
    end else begin
      o_sof <= 1'b0;
      o_eof <= 1'b0;
      o_wr  <= 1'b0;

      if (ovf_set)
        o_ovf <= 1'b1;
      else if (i_clr_ovf)
        o_ovf <= 1'b0;

      if (!i_cfg_done) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_WAIT_SOF;

          ST_WAIT_SOF: begin
            if (vs_fall) begin
              o_sof   <= 1'b1;
              xs      <= i_x_start;
              xe      <= i_x_end;
              ys      <= i_y_start;
              ye      <= i_y_end;
              decim_l <= i_decim;
              x       <= '0;
              y       <= '0;
              drop    <= 1'b0;
              state   <= ST_ACTIVE;
            end
          end

          ST_ACTIVE: begin
            if (vs_rise) begin
              o_eof <= 1'b1;
              if (!drop)
                o_frame_cnt <= o_frame_cnt + 1'b1;
              state <= ST_WAIT_SOF;
            end else begin
              if (wr_elig) begin
                if (i_fifo_almostfull) begin
                  drop <= 1'b1;
                end else begin
                  o_wr    <= 1'b1;
                  o_wdata <= pix;
                end
              end
              // The last pixel of a line completes on the same edge the href fall is seen.
              if (href_fall) begin
                x <= '0;
                if (y != '1)
                  y <= y + 1'b1;
              end else if (pix_valid && (x != '1)) begin
                x <= x + 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_win.sv
// Self-checking bench for cam_capture_win: drives camera frames, predicts
// FIFO writes into a scoreboard queue and checks frame strobes, count and overflow.
module tb_cam_capture_win;

  localparam int DW = 8;
  localparam int BP = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int FW = 3;

  logic           clk;
  logic           rstn;
  logic           cfg_done;
  logic           vsync;
  logic           href;
  logic [DW-1:0]  i_data;
  logic [XW-1:0]  x_start, x_end;
  logic [YW-1:0]  y_start, y_end;
  logic [1:0]     decim;
  logic           fifo_af;
  logic           clr_ovf;
  logic           o_wr;
  logic [DW*BP-1:0] o_wdata;
  logic           o_sof, o_eof;
  logic [FW-1:0]  o_frame_cnt;
  logic           o_ovf;

  cam_capture_win #(
    .DATA_W (DW),
    .BPP    (BP),
    .X_W    (XW),
    .Y_W    (YW),
    .FCNT_W (FW)
  ) dut (
    .i_pclk            (clk),
    .i_rstn            (rstn),
    .i_cfg_done        (cfg_done),
    .i_vsync           (vsync),
    .i_href            (href),
    .i_data            (i_data),
    .i_x_start         (x_start),
    .i_x_end           (x_end),
    .i_y_start         (y_start),
    .i_y_end           (y_end),
    .i_decim           (decim),
    .i_fifo_almostfull (fifo_af),
    .i_clr_ovf         (clr_ovf),
    .o_wr              (o_wr),
    .o_wdata           (o_wdata),
    .o_sof             (o_sof),
    .o_eof             (o_eof),
    .o_frame_cnt       (o_frame_cnt),
    .o_ovf             (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  int sof_seen = 0, eof_seen = 0, both_seen = 0;
  int sof0, eof0;
  int fcnt_m = 0;
  int xs_l, xe_l, ys_l, ye_l, dec_l;
  bit dropped;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (o_sof) sof_seen++;
      if (o_eof) eof_seen++;
      if (o_sof && o_eof) both_seen++;
      if (o_wr) begin
        check_val("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check_val("wdata", 64'(o_wdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [15:0] pix_val(input int col, input int yy, input int pat);
    if (pat == 0) return 16'hABCD;
    return {8'(col), 8'(yy) ^ 8'h5A};
  endfunction

  function automatic bit elig(input int xx, input int yy);
    if (xx < xs_l || xx > xe_l || yy < ys_l || yy > ye_l) return 1'b0;
    return ((xx - xs_l) % (1 << dec_l) == 0) && ((yy - ys_l) % (1 << dec_l) == 0);
  endfunction

  task automatic set_win(input int xs, input int xe, input int ys, input int ye, input int d);
    x_start = XW'(xs);
    x_end   = XW'(xe);
    y_start = YW'(ys);
    y_end   = YW'(ye);
    decim   = 2'(d);
  endtask

  // part_line: line ending with a lone byte; af_at: eligible pixel index that meets
  // back-pressure; cfg_drop_line/rst_line: line after/during which cfg or reset hits.
  task automatic drive_frame(input int ncols, input int nlines, input int pat,
                             input int part_line, input int af_at, input int cfg_drop_line,
                             input int rst_line, input bit win_change);
    int elig_n = 0;
    bit active_m = 1'b1;
    bit af_next = 1'b0;
    int xm;
    logic [15:0] pv;
    sof0 = sof_seen;
    eof0 = eof_seen;
    vsync = 1'b1;
    idle(4);
    xs_l = int'(x_start); xe_l = int'(x_end);
    ys_l = int'(y_start); ye_l = int'(y_end);
    dec_l = int'(decim);
    dropped = 1'b0;
    vsync = 1'b0;
    idle(6);
    for (int yy = 0; yy < nlines; yy++) begin
      href = 1'b1;
      for (int col = 0; col < ncols; col++) begin
        pv = pix_val(col, yy, pat);
        for (int b = 0; b < 2; b++) begin
          if (af_next) begin
            fifo_af = 1'b1;
            af_next = 1'b0;
          end
          i_data = (b == 0) ? pv[15:8] : pv[7:0];
          if (b == 1) begin
            if (yy == rst_line && col == ncols / 2) begin
              rstn = 1'b0;
              #1;
              check_val("rst_async_outputs",
                        64'({o_wr, o_sof, o_eof, o_ovf, o_frame_cnt, o_wdata}), 64'd0);
              exp_q.delete();
              fcnt_m = 0;
              href = 1'b0;
              i_data = '0;
              return;
            end
            xm = (col > (1 << XW) - 1) ? (1 << XW) - 1 : col;
            if (active_m && !dropped && elig(xm, yy)) begin
              elig_n++;
              if (af_at != 0 && elig_n == af_at) begin
                dropped = 1'b1;
                af_next = 1'b1;
              end else begin
                exp_q.push_back(pv);
              end
            end
          end
          tick();
        end
      end
      if (yy == part_line) begin
        i_data = 8'hEE;
        tick();
      end
      href = 1'b0;
      i_data = '0;
      idle(5);
      if (yy == cfg_drop_line) begin
        cfg_done = 1'b0;
        active_m = 1'b0;
        idle(3);
      end
      if (cfg_drop_line >= 0 && yy == cfg_drop_line + 1)
        cfg_done = 1'b1;
      if (win_change && yy == 1)
        set_win(0, 23, 0, 9, 0);
    end
    vsync = 1'b1;
    idle(6);
    fifo_af = 1'b0;
    if (active_m && !dropped)
      fcnt_m = (fcnt_m + 1) % (1 << FW);
  endtask

  task automatic after_frame(input string tag, input int exp_eof, input logic exp_ovf);
    check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_sof"}, 64'(sof_seen - sof0), 64'd1);
    check_val({tag, "_eof"}, 64'(eof_seen - eof0), 64'(exp_eof));
    check_val({tag, "_fcnt"}, 64'(o_frame_cnt), 64'(fcnt_m));
    check_val({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ovf));
  endtask

  initial begin
    rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0; i_data = '0;
    fifo_af = 1'b0; clr_ovf = 1'b0;
    set_win(0, 23, 0, 9, 0);
    idle(3);
    check_val("reset_outputs",
              64'({o_wr, o_sof, o_eof, o_ovf, o_frame_cnt, o_wdata}), 64'd0);
    rstn = 1'b1;
    idle(2);
    cfg_done = 1'b1;
    idle(2);

    // Full window, constant pixel
    drive_frame(24, 10, 0, -1, 0, -1, -1, 1'b0);
    after_frame("full", 1, 1'b0);

    // Cropped, decimated; window inputs change mid-frame
    set_win(10, 19, 5, 6, 1);
    drive_frame(24, 10, 1, -1, 0, -1, -1, 1'b1);
    after_frame("crop_decim", 1, 1'b0);

    // Empty window still counts as a good frame
    set_win(5, 4, 0, 9, 0);
    drive_frame(24, 10, 1, -1, 0, -1, -1, 1'b0);
    after_frame("empty_win", 1, 1'b0);

    // Back-pressure at the 100th eligible pixel, then a clean frame
    set_win(0, 23, 0, 9, 0);
    drive_frame(24, 10, 1, -1, 100, -1, -1, 1'b0);
    after_frame("af_drop", 1, 1'b1);
    drive_frame(24, 10, 1, -1, 0, -1, -1, 1'b0);
    after_frame("af_recover", 1, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    idle(1);
    check_val("ovf_cleared", 64'(o_ovf), 64'd0);

    // Partial pixel at end of line 3
    set_win(0, 1023, 0, 511, 0);
    drive_frame(24, 10, 1, 3, 0, -1, -1, 1'b0);
    after_frame("partial", 1, 1'b0);

    // Column counter saturation must not wrap back into x 0..3
    set_win(0, 3, 0, 0, 0);
    drive_frame(1030, 1, 1, -1, 0, -1, -1, 1'b0);
    after_frame("x_sat", 1, 1'b0);

    // cfg_done dropped mid-frame, then a normal frame
    set_win(0, 23, 0, 9, 0);
    drive_frame(24, 10, 1, -1, 0, 4, -1, 1'b0);
    after_frame("cfg_drop", 0, 1'b0);
    drive_frame(24, 10, 1, -1, 0, -1, -1, 1'b0);
    after_frame("cfg_resume", 1, 1'b0);

    // Short frames to wrap the frame counter
    set_win(0, 3, 0, 1, 0);
    for (int f = 0; f < 3; f++) begin
      drive_frame(4, 2, 1, -1, 0, -1, -1, 1'b0);
      after_frame("wrap", 1, 1'b0);
    end

    // Asynchronous reset mid-line, then restart
    set_win(0, 23, 0, 9, 0);
    drive_frame(24, 10, 1, -1, 0, -1, 4, 1'b0);
    idle(3);
    rstn = 1'b1;
    idle(3);
    drive_frame(24, 10, 1, -1, 0, -1, -1, 1'b0);
    after_frame("post_reset", 1, 1'b0);

    check_val("sof_eof_exclusive", 64'(both_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
